// File: rtl/dtree_seq_engine.sv
// Time-multiplexed decision-tree classifier: walks a programmable node table
// one node per clock and returns the class of the leaf it reaches, or an abort.
module dtree_seq_engine #(
    parameter int N_FEAT    = 5,
    parameter int FEAT_W    = 8,
    parameter int FIDX_W    = 3,
    parameter int NODE_AW   = 4,
    parameter int N_NODES   = 15,
    parameter int CLASS_W   = 3,
    parameter int MAX_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cfg_we,
    input  logic [NODE_AW-1:0]                    cfg_addr,
    input  logic [FIDX_W+FEAT_W+2*NODE_AW:0]      cfg_wdata,
    output logic                                  cfg_ack,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_FEAT*FEAT_W-1:0]              in_feat,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [CLASS_W-1:0]                    out_class,
    output logic                                  out_err
);

    localparam int WORD_W     = 1 + FIDX_W + FEAT_W + 2 * NODE_AW;
    localparam int NODE_DEPTH = 2 ** NODE_AW;
    localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1);

    localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(MAX_DEPTH - 1);
    localparam logic [FIDX_W:0]    FEAT_LIMIT = (FIDX_W + 1)'(N_FEAT);
    localparam logic [NODE_AW:0]   NODE_LIMIT = (NODE_AW + 1)'(N_NODES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state;
    logic [NODE_AW-1:0]      ptr;
    logic [DEPTH_W-1:0]      depth;
    logic [N_FEAT*FEAT_W-1:0] feat_reg;
    logic [WORD_W-1:0]       node_mem [NODE_DEPTH];

    // Decoded fields of the node currently addressed by ptr.
    logic [WORD_W-1:0]  node_word;
    logic               node_internal;
    logic [FIDX_W-1:0]  node_fidx;
    logic [FEAT_W-1:0]  node_thr;
    logic [NODE_AW-1:0] node_left;
    logic [NODE_AW-1:0] node_right;
    logic [FEAT_W-1:0]  feat_sel;
    logic [NODE_AW-1:0] child;
    logic               node_err;

    assign node_word     = node_mem[ptr];
    assign node_internal = node_word[WORD_W-1];
    assign node_fidx     = node_word[WORD_W-2 -: FIDX_W];
    assign node_thr      = node_word[2*NODE_AW +: FEAT_W];
    assign node_left     = node_word[NODE_AW +: NODE_AW];
    assign node_right    = node_word[0 +: NODE_AW];

    // NOTE: default assignment first so every path writes feat_sel and no latch is inferred.
    always_comb begin
        feat_sel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (node_fidx == FIDX_W'(i)) feat_sel = feat_reg[i*FEAT_W +: FEAT_W];
        end
    end

    assign child    = (feat_sel <= node_thr) ? node_left : node_right;
    assign node_err = (depth == DEPTH_LAST)
                   || ({1'b0, child} >= NODE_LIMIT)
                   || ({1'b0, node_fidx} >= FEAT_LIMIT);

    // A config write in the same cycle takes priority over a new vector.
    assign in_ready = (state == ST_IDLE) && !cfg_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            depth     <= '0;
            feat_reg  <= '0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
            cfg_ack   <= 1'b0;
            // NOTE: the node table is flop-based and cleared on reset so an unprogrammed table is a class-0 leaf.
            for (int i = 0; i < NODE_DEPTH; i++) node_mem[i] <= '0;
        end else begin
            cfg_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        node_mem[cfg_addr] <= cfg_wdata;
                        cfg_ack            <= 1'b1;
                    end else if (in_valid) begin
                        feat_reg <= in_feat;
                        ptr      <= '0;
                        depth    <= '0;
                        state    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (!node_internal) begin
                        out_class <= node_thr[CLASS_W-1:0];
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else if (node_err) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        ptr   <= child;
                        depth <= depth + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dtree_seq_engine.md
Name: dtree_seq_engine

Overview:
- Programmable, time-multiplexed decision-tree classifier: evaluates one tree node per clock from an on-chip node table, instead of a fixed hard-wired comparator tree.
- Parametrised in feature count, feature width, node count, class width and maximum depth.
- Sits between the sensor/feature front-end (valid/ready) and the class consumer.
- Tree contents are loaded through a config write port, so one netlist serves any trained model.

Parameters:
- N_FEAT, 5, number of input features
- FEAT_W, 8, bits per feature and per threshold
- FIDX_W, 3, feature-index field width; requires 2**FIDX_W >= N_FEAT
- NODE_AW, 4, node address width; table depth is 2**NODE_AW
- N_NODES, 15, populated nodes; requires N_NODES <= 2**NODE_AW
- CLASS_W, 3, class output width; requires CLASS_W <= FEAT_W
- MAX_DEPTH, 8, maximum internal nodes on any path before the error abort

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  node-table write strobe
- cfg_addr  in  NODE_AW  node address
- cfg_wdata  in  1+FIDX_W+FEAT_W+2*NODE_AW  node word: {internal, feat_idx, thr, left, right}, MSB first
- cfg_ack  out  1  registered; 1 for one cycle after a write is accepted
- in_valid  in  1  feature vector valid
- in_ready  out  1  engine can accept a vector
- in_feat  in  N_FEAT*FEAT_W  feature i at [i*FEAT_W +: FEAT_W]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  CLASS_W  class of the reached leaf
- out_err  out  1  abort flag accompanying out_valid

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; out_valid=0, out_class=0, out_err=0, cfg_ack=0; pointer and depth counters cleared.
  - Every node-table word is cleared to 0. A zero word decodes as a leaf of class 0.
  - Reset mid-evaluation or mid-handshake aborts; no result is produced.
- Node decode:
  - internal=0: leaf; class = thr[CLASS_W-1:0].
  - internal=1: compare in_feat_reg[feat_idx] <= thr, unsigned. True -> left child; false -> right child.
- FSM states IDLE, EVAL, DONE.
  - IDLE: in_ready=1 unless cfg_we=1 in the same cycle.
    - cfg_we=1: table[cfg_addr] <= cfg_wdata; cfg_ack=1 next cycle.
    - If cfg_we and in_valid are both 1, the config write wins and the vector is not accepted.
    - in_valid && in_ready: capture in_feat into an internal register; ptr<=0, depth<=0; go to EVAL.
  - EVAL: in_ready=0; cfg_we is ignored (no write, no cfg_ack). One node per cycle at table[ptr]:
    - Leaf: out_class<=class, out_err<=0, out_valid<=1; go to DONE.
    - Internal: ptr<=child, depth<=depth+1.
    - Error: depth==MAX_DEPTH-1 on an internal node, or child >= N_NODES, or feat_idx >= N_FEAT. Then out_class<=0, out_err<=1, out_valid<=1; go to DONE.
  - DONE: hold out_valid, out_class and out_err stable. On out_ready=1, clear out_valid and go to IDLE. in_ready stays 0 in DONE (no overlap).
- Latency: with the acceptance edge at k and a path of d internal nodes to the leaf, out_valid is high after edge k+d+1. Minimum is 1 cycle (root is a leaf). Worst case is MAX_DEPTH cycles to the error result.
- Throughput: one vector per (latency + 1) cycles minimum; out_ready held at 1 gives IDLE for one cycle between results.
- in_feat may change after acceptance without affecting the result.
- cfg_addr >= N_NODES is writable but unreachable during evaluation.

Test Plan:
- Reset → out_valid=0, out_class=0, out_err=0, in_ready=1. Send any vector → out_valid after 1 cycle, class 0, err 0.
- Program tree: n0={1,4,127,1,2}, n1={0,0,3,0,0}, n2={1,0,95,3,4}, n3={0,0,5,0,0}, n4={0,0,2,0,0}. X4=200, X0=80 → class 5, out_valid 3 cycles after acceptance. X4=100 → class 3 after 2 cycles. X4=200, X0=96 → class 2.
- Self-loop n0={1,0,255,0,0} → err=1, class 0 exactly MAX_DEPTH=8 cycles after acceptance. n0 left=15 (>=N_NODES) → err=1 after 1 cycle.
- cfg_we during EVAL to n3 with class 7 → no cfg_ack, and the result is still 5. Same write in IDLE → cfg_ack pulse, and the next run gives 7. cfg_we together with in_valid in IDLE → write done, vector not accepted (in_ready=0).
- out_ready=0 for 10 cycles after a result → out_valid, class and err stable, in_ready=0. out_ready=1 → out_valid drops the next cycle and in_ready returns.
- rst_n=0 for 1 cycle during EVAL on the depth-2 path → no out_valid. The table is cleared, so the next vector yields class 0 after 1 cycle.
